hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Hazard and forwarding controller for the 5-stage pipeline.
- Produces the 2-bit operand-select codes consumed by the EX-stage 3-input forwarding muxes, plus stall/flush controls for the pipeline registers.
- Adds a small FSM that holds the pipeline while a multi-cycle mul/div op occupies EX.

Parameters:
- REG_AW, 5, register address width.
- MD_LATENCY, 4, EX cycles a mul/div op occupies (>=2).
- CNT_W, 3, width of the mul/div cycle counter (must hold MD_LATENCY-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Rs1D  in  REG_AW  rs1 address in ID.
- Rs2D  in  REG_AW  rs2 address in ID.
- Rs1E  in  REG_AW  rs1 address in EX.
- Rs2E  in  REG_AW  rs2 address in EX.
- RdE  in  REG_AW  destination in EX.
- RdM  in  REG_AW  destination in MEM.
- RdW  in  REG_AW  destination in WB.
- RegWriteM  in  1  MEM instruction writes rd.
- RegWriteW  in  1  WB instruction writes rd.
- LoadE  in  1  EX instruction is a load.
- PCSrcE  in  1  branch/jump taken, resolved in EX.
- MdStartE  in  1  EX instruction is mul/div; valid on its first EX cycle.
- ForwardAE  out  2  srcA select.
- ForwardBE  out  2  srcB select.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- StallE  out  1  hold ID/EX.
- FlushD  out  1  clear IF/ID.
- FlushE  out  1  clear ID/EX.
- FlushM  out  1  clear EX/MEM (bubble).
- MdDone  out  1  mul/div result valid this cycle.

Behaviour:
- Forward encoding:
  - 00 = register-file value.
  - 01 = WB result.
  - 10 = MEM-stage ALU result.
  - 11 is never driven.
- ForwardAE (combinational):
  - 10 if RegWriteM & RdM==Rs1E & Rs1E!=0.
  - Else 01 if RegWriteW & RdW==Rs1E & Rs1E!=0.
  - Else 00.
  - MEM has priority over WB (newest value wins).
- ForwardBE: identical rule using Rs2E.
- Register x0 never forwards, even when RdM/RdW==0 with RegWrite set.
- Load-use stall:
  - lwStall = LoadE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
  - Effect: StallF = StallD = 1 and FlushE = 1 for exactly one cycle.
- Mul/div FSM, states IDLE and BUSY, counter cnt:
  - IDLE -> BUSY when MdStartE=1; cnt loads MD_LATENCY-2.
  - BUSY: StallF = StallD = StallE = 1, FlushM = 1. If cnt==0, assert MdDone and go to IDLE next cycle; otherwise cnt decrements.
  - In BUSY, all stalls deassert in the cycle MdDone=1 so the result advances to MEM next edge.
  - Total EX occupancy is MD_LATENCY cycles: the IDLE start cycle plus MD_LATENCY-1 BUSY cycles.
  - The start cycle itself also asserts StallF/StallD/StallE/FlushM.
- MdStartE is ignored while BUSY; the held ID/EX register keeps it high.
- Priority when events coincide:
  - Mul/div stall outranks lwStall: FlushE is suppressed while StallE=1.
  - PCSrcE always asserts FlushD and FlushE.
  - PCSrcE and lwStall in the same cycle: both flushes are asserted; StallF/StallD are still asserted; the fetch redirect is owned by the PC mux.
  - PCSrcE never coincides with MdStartE/BUSY (a mul/div op is not a branch); no requirement applies to that case.
- Reset (asynchronous, any time, including mid-BUSY):
  - state = IDLE, cnt = 0.
  - All stall/flush outputs, MdDone = 0, Forward codes = 00.
  - Forward outputs stay combinational from inputs after reset deasserts.

Decomposition:
- Shared package cpu_pkg:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - md_state_t: IDLE, BUSY.
  - REG_AW.
- One natural sub-module: fwd_select. Instantiated twice (A and B); computes one Forward code from rsE, RdM, RdW, RegWriteM, RegWriteW.
- FSM and stall logic stay in hazard_unit.

Test Plan:
- Forward priority:
  - Rs1E=5, RdM=5, RegWriteM=1 -> ForwardAE=10.
  - Additionally RdW=5, RegWriteW=1 -> ForwardAE stays 10.
  - Then RegWriteM=0 -> ForwardAE=01.
- x0 suppression: Rs2E=0, RdM=0, RegWriteM=1 -> ForwardBE=00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; next cycle with LoadE=0, all are 0.
- Mul/div (MD_LATENCY=4): MdStartE=1 at cycle 0 -> stalls and FlushM high in cycles 0-2; MdDone=1 in cycle 3 with stalls low; state IDLE in cycle 4.
- Branch flush: PCSrcE=1 with LoadE=1, RdE=3, Rs1D=3 -> FlushD=FlushE=1, StallF=StallD=1.
- Reset mid-op: assert reset in cycle 1 of BUSY -> all outputs 0 immediately (asynchronous); after release with MdStartE=0, no stall is asserted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline types: forwarding-mux select codes and mul/div FSM states.
package cpu_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_unit_fwd_select.sv
// One EX-operand forwarding select: newest producer (MEM) wins over WB; x0 never forwards.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int AW = cpu_pkg::REG_AW
) (
  input  logic [AW-1:0] rs_e_i,
  input  logic [AW-1:0] rd_m_i,
  input  logic [AW-1:0] rd_w_i,
  input  logic          reg_write_m_i,
  input  logic          reg_write_w_i,
  output fwd_sel_t      sel_o
);

  logic rs_nonzero;

  assign rs_nonzero = (rs_e_i != '0);

  always_comb begin
    sel_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i == rs_e_i) && rs_nonzero) begin
      sel_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i == rs_e_i) && rs_nonzero) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller: EX operand selects, load-use stall, branch flush,
// and a hold FSM that keeps the pipeline frozen while a multi-cycle mul/div sits in EX.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW     = cpu_pkg::REG_AW,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MdStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MdDone
);

  fwd_sel_t             fwd_a;
  fwd_sel_t             fwd_b;
  md_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 lw_stall;
  logic                 md_hold;
  logic                 md_done;

  fwd_select #(.AW(REG_AW)) u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .sel_o         (fwd_a)
  );

  fwd_select #(.AW(REG_AW)) u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .sel_o         (fwd_b)
  );

  assign lw_stall = LoadE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MdStartE stays high while the op is held in EX, so it only matters in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MdStartE) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MD_LATENCY - 2);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Hold covers the start cycle and every BUSY cycle except the final one,
  // which releases the stalls so the result moves on to MEM.
  always_comb begin
    md_hold = 1'b0;
    md_done = 1'b0;
    case (state_q)
      IDLE:    md_hold = MdStartE;
      BUSY: begin
        md_hold = (cnt_q != '0);
        md_done = (cnt_q == '0);
      end
      default: md_hold = 1'b0;
    endcase
  end

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    MdDone    = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      StallF    = md_hold || lw_stall;
      StallD    = md_hold || lw_stall;
      StallE    = md_hold;
      FlushD    = PCSrcE;
      FlushE    = PCSrcE || (lw_stall && !md_hold);
      FlushM    = md_hold;
      MdDone    = md_done;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed checks of hazard_unit: forwarding priority, x0, load-use, mul/div hold, branch flush, async reset.
module tb_hazard_unit;
  import cpu_pkg::*;

  logic       clk;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdDone;
  logic [6:0] ctrl;

  int checks;
  int failures;

  hazard_unit #(.REG_AW(5), .MD_LATENCY(4), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .Rs1E      (Rs1E),
    .Rs2E      (Rs2E),
    .RdE       (RdE),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .LoadE     (LoadE),
    .PCSrcE    (PCSrcE),
    .MdStartE  (MdStartE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .StallF    (StallF),
    .StallD    (StallD),
    .StallE    (StallE),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .FlushM    (FlushM),
    .MdDone    (MdDone)
  );

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdDone}
  assign ctrl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdDone};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    LoadE = 1'b0; PCSrcE = 1'b0; MdStartE = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear_inputs();

    // Reset: outputs forced low even with a forwarding match and a load-use hazard present.
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #13;
    check("reset_ctrl", {1'b0, ctrl}, 8'h00);
    check("reset_fwdA", {6'd0, ForwardAE}, 8'h00);
    check("reset_state", {7'd0, dut.state_q}, {7'd0, IDLE});
    reset = 1'b0;
    clear_inputs();
    tick();

    // Forwarding priority on A.
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    #1 check("fwdA_mem", {6'd0, ForwardAE}, 8'h02);
    RdW = 5'd5; RegWriteW = 1'b1;
    #1 check("fwdA_mem_over_wb", {6'd0, ForwardAE}, 8'h02);
    RegWriteM = 1'b0;
    #1 check("fwdA_wb", {6'd0, ForwardAE}, 8'h01);
    RdW = 5'd6;
    #1 check("fwdA_none", {6'd0, ForwardAE}, 8'h00);

    // x0 never forwards, then B forwarding from MEM and WB.
    clear_inputs();
    Rs2E = 5'd0; RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd0; RegWriteW = 1'b1;
    #1 check("fwdB_x0", {6'd0, ForwardBE}, 8'h00);
    Rs2E = 5'd9; RdM = 5'd9;
    #1 check("fwdB_mem", {6'd0, ForwardBE}, 8'h02);
    RegWriteM = 1'b0; RdW = 5'd9;
    #1 check("fwdB_wb", {6'd0, ForwardBE}, 8'h01);
    check("fwdA_idle_with_B", {6'd0, ForwardAE}, 8'h00);

    // Load-use stall, one cycle only.
    clear_inputs();
    tick();
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1 check("lw_stall", {1'b0, ctrl}, 8'b0110_0100);
    tick();
    LoadE = 1'b0;
    #1 check("lw_released", {1'b0, ctrl}, 8'h00);
    LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    #1 check("lw_x0_no_stall", {1'b0, ctrl}, 8'h00);

    // Mul/div hold, MD_LATENCY = 4.
    clear_inputs();
    tick();
    MdStartE = 1'b1;
    #1 check("md_c0", {1'b0, ctrl}, 8'b0111_0010);
    tick();
    LoadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
    #1 check("md_c1_lw_flushE_suppressed", {1'b0, ctrl}, 8'b0111_0010);
    LoadE = 1'b0; RdE = 5'd0; Rs1D = 5'd0;
    tick();
    #1 check("md_c2", {1'b0, ctrl}, 8'b0111_0010);
    tick();
    #1 check("md_c3_done", {1'b0, ctrl}, 8'b0000_0001);
    tick();
    MdStartE = 1'b0;
    #1 check("md_c4_ctrl", {1'b0, ctrl}, 8'h00);
    check("md_c4_state", {7'd0, dut.state_q}, {7'd0, IDLE});

    // Branch taken with a simultaneous load-use hazard, then branch alone.
    clear_inputs();
    tick();
    PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
    #1 check("branch_lw", {1'b0, ctrl}, 8'b0110_1100);
    LoadE = 1'b0;
    #1 check("branch_only", {1'b0, ctrl}, 8'b0000_1100);

    // Asynchronous reset in the middle of a BUSY sequence.
    clear_inputs();
    tick();
    MdStartE = 1'b1;
    tick();
    #1 check("rst_mid_busy_pre", {1'b0, ctrl}, 8'b0111_0010);
    RdM = 5'd8; Rs1E = 5'd8; RegWriteM = 1'b1;
    reset = 1'b1;
    #1 check("rst_mid_ctrl", {1'b0, ctrl}, 8'h00);
    check("rst_mid_fwdA", {6'd0, ForwardAE}, 8'h00);
    check("rst_mid_cnt", {5'd0, dut.cnt_q}, 8'h00);
    MdStartE = 1'b0;
    tick();
    reset = 1'b0;
    #1 check("rst_release_fwdA", {6'd0, ForwardAE}, 8'h02);
    tick();
    #1 check("rst_after_c1", {1'b0, ctrl}, 8'h00);
    tick();
    #1 check("rst_after_c2", {1'b0, ctrl}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
